palin_bit_collector: RTL

- Serial-to-parallel front end that sits directly upstream of the combinational palindrome checker.
- Accepts a bit stream under a valid/ready handshake and assembles N-bit words MSB-first.
- Presents each completed word on a registered valid/ready output whose data bus drives the checker's data input.
- Provides back-pressure so no bit is ever dropped.

---
 rtl/palin_bit_collector.sv | 58 +++++
 1 files changed

// File: rtl/palin_bit_collector.sv
// rtl/palin_bit_collector.sv - serial bit stream to N-bit word collector, MSB first
// Feeds the palindrome checker through a registered valid/ready word output.
module palin_bit_collector #(
  parameter int N = 9,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          bit_ready,
  input  logic          flush,
  output logic [N-1:0]  word_out,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [CW-1:0] bit_count
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-2:0] sh;
  logic [N-1:0] next_word;
  logic         accept;
  logic         complete;

  assign next_word = {sh, bit_in};

  // Only the completing bit stalls, and only while the held word is not leaving.
  assign bit_ready = !((bit_count == LAST) && word_valid && !word_ready);
  assign accept    = bit_valid && bit_ready && !flush;
  assign complete  = accept && (bit_count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh         <= '0;
      bit_count  <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      if (flush) begin
        sh        <= '0;
        bit_count <= '0;
      end else if (accept) begin
        sh        <= next_word[N-2:0];
        bit_count <= complete ? '0 : bit_count + 1'b1;
      end

      // A new word completing on the consume edge replaces the old one with no bubble.
      if (complete) begin
        word_out   <= next_word;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule
